// File: rtl/mul_result_accumulator_if.sv
// -----------------------------------------------------------------------------
// mul_result_accumulator_if
//
// Purpose:
//   Bundles the handshake and data signals between the multiplier-result
//   accumulator and its neighbours: the product stream coming in from the
//   16x16 multiplier, the run control (start / num_terms), and the result
//   handshake going out to the consumer.
//
// Signals:
//   start       run request, honoured only while the accumulator is idle
//   num_terms   number of products to sum, sampled together with start
//   prod_valid  prod_in carries a valid product this cycle
//   prod_in     unsigned product from the multiplier
//   prod_ready  accumulator accepts a product this cycle
//   acc_out     accumulated sum, stable while acc_valid is high
//   acc_valid   acc_out is final
//   acc_ack     consumer has taken acc_out
//   overflow    sticky wrap flag for the current run
//   busy        accumulator is not idle
//
// Modports:
//   master  drives the run control, the products and the acknowledge
//   slave   the accumulator itself
// -----------------------------------------------------------------------------
interface mul_result_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 5
) ();

    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_in;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ack;
    logic              overflow;
    logic              busy;

    modport master (
        output start,
        output num_terms,
        output prod_valid,
        output prod_in,
        output acc_ack,
        input  prod_ready,
        input  acc_out,
        input  acc_valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  start,
        input  num_terms,
        input  prod_valid,
        input  prod_in,
        input  acc_ack,
        output prod_ready,
        output acc_out,
        output acc_valid,
        output overflow,
        output busy
    );

endinterface

// File: rtl/mul_result_accumulator.sv
// -----------------------------------------------------------------------------
// mul_result_accumulator
//
// Purpose:
//   Downstream stage of the 16x16 unsigned multiplier. Sums a programmed
//   number of 32-bit products into a wide accumulator and presents the result
//   through a valid/ack handshake, with a sticky overflow flag that marks a
//   wrap of the accumulator during the run. Typical use is a dot product,
//   sum of A[k]*B[k].
//
// Parameters:
//   PROD_W     width of an incoming product
//   ACC_W      accumulator width, at least PROD_W
//   MAX_TERMS  largest number of products per run; bigger requests clamp
//   CNT_W      width of num_terms and of the term counter
//
// Ports:
//   clk    clock, every state update on its rising edge
//   reset  synchronous, active-low reset
//   bus    slave side of mul_result_accumulator_if (see that file)
//
// Operation:
//   IDLE  : start with num_terms != 0 clears the sum and flag, loads the
//           clamped term count and moves to ACCUM; start with num_terms == 0
//           clears the sum and flag and moves straight to HOLD.
//   ACCUM : prod_ready is high; each prod_valid cycle adds the zero-extended
//           product (modulo 2^ACC_W) and counts one term down. The last term
//           moves to HOLD.
//   HOLD  : acc_valid is high and the result is frozen until acc_ack.
//   All outputs are registered; the handshake flags are computed from the
//   next state so that they line up with the state they describe.
// -----------------------------------------------------------------------------
module mul_result_accumulator #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    mul_result_accumulator_if.slave  bus
);

    // FSM encoding kept as plain constants for compatibility with older flows.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] MAX_TERMS_C = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C      = CNT_W'(0);
    localparam logic [ACC_W-1:0] ACC_ZERO_C  = ACC_W'(0);

    logic [1:0]       state_q,      state_d;
    logic [ACC_W-1:0] acc_q,        acc_d;
    logic             overflow_q,   overflow_d;
    logic [CNT_W-1:0] remaining_q,  remaining_d;
    logic             prod_ready_q, prod_ready_d;
    logic             acc_valid_q,  acc_valid_d;
    logic             busy_q,       busy_d;

    logic             xfer_s;
    logic [ACC_W:0]   sum_s;
    logic [CNT_W-1:0] terms_s;

    // Datapath helpers: clamped term count, transfer strobe and the widened
    // add whose top bit is the carry out of the accumulator.
    always_comb begin
        if (bus.num_terms > MAX_TERMS_C) begin
            terms_s = MAX_TERMS_C;
        end else begin
            terms_s = bus.num_terms;
        end
        xfer_s = (state_q == ST_ACCUM) && bus.prod_valid;
        sum_s  = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, bus.prod_in};
    end

    // Next-state logic for the FSM, the sum, the flag and the term counter.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        overflow_d  = overflow_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d      = ACC_ZERO_C;
                    overflow_d = 1'b0;
                    if (terms_s != ZERO_C) begin
                        remaining_d = terms_s;
                        state_d     = ST_ACCUM;
                    end else begin
                        // Empty run: the zero result is presented right away.
                        remaining_d = ZERO_C;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                if (xfer_s) begin
                    acc_d       = sum_s[ACC_W-1:0];
                    overflow_d  = overflow_q | sum_s[ACC_W];
                    remaining_d = remaining_q - ONE_C;
                    if (remaining_q == ONE_C) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    // Gaps in the product stream leave everything untouched.
                    state_d = ST_ACCUM;
                end
            end

            ST_HOLD: begin
                // start is deliberately not looked at here, even with acc_ack.
                if (bus.acc_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                remaining_d = ZERO_C;
            end
        endcase

        // Output flags follow the state being entered so they stay registered
        // yet valid in the same cycle as the state they describe.
        prod_ready_d = (state_d == ST_ACCUM);
        acc_valid_d  = (state_d == ST_HOLD);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= ACC_ZERO_C;
            overflow_q   <= 1'b0;
            remaining_q  <= ZERO_C;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            overflow_q   <= overflow_d;
            remaining_q  <= remaining_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Drive the interface outputs straight from the registers.
    always_comb begin
        bus.prod_ready = prod_ready_q;
        bus.acc_out    = acc_q;
        bus.acc_valid  = acc_valid_q;
        bus.overflow   = overflow_q;
        bus.busy       = busy_q;
    end

endmodule

// File: tb/tb_mul_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mul_result_accumulator
//
// Two accumulators (ACC_W=40 and ACC_W=32) receive identical stimulus. A
// transaction-level model tracks the exact integer sum of the run and derives
// each instance's expected output as the sum modulo 2^ACC_W, with overflow
// meaning the true sum no longer fits. Outputs are compared every cycle on
// the falling edge; directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_mul_result_accumulator;

    localparam int PROD_W = 32;
    localparam int CNT_W  = 5;
    localparam int MAXT   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_in;
    logic              acc_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_result_accumulator_if #(.PROD_W(PROD_W), .ACC_W(40), .CNT_W(CNT_W)) if40 ();
    mul_result_accumulator_if #(.PROD_W(PROD_W), .ACC_W(32), .CNT_W(CNT_W)) if32 ();

    assign if40.start = start;      assign if32.start = start;
    assign if40.num_terms = num_terms; assign if32.num_terms = num_terms;
    assign if40.prod_valid = prod_valid; assign if32.prod_valid = prod_valid;
    assign if40.prod_in = prod_in;  assign if32.prod_in = prod_in;
    assign if40.acc_ack = acc_ack;  assign if32.acc_ack = acc_ack;

    mul_result_accumulator #(.PROD_W(PROD_W), .ACC_W(40), .MAX_TERMS(MAXT), .CNT_W(CNT_W))
        dut40 (.clk(clk), .reset(reset), .bus(if40.slave));
    mul_result_accumulator #(.PROD_W(PROD_W), .ACC_W(32), .MAX_TERMS(MAXT), .CNT_W(CNT_W))
        dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Exact sum of the products of the current run; widths applied at compare.
    longint unsigned m_sum  = 0;
    int              m_left = 0;
    bit              m_run  = 1'b0;
    bit              m_done = 1'b0;
    bit              m_live = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_sum  <= 0;
            m_left <= 0;
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_live <= 1'b1;
        end else if (m_done) begin
            if (acc_ack) m_done <= 1'b0;
        end else if (m_run) begin
            if (prod_valid) begin
                m_sum  <= m_sum + longint'(prod_in);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (start) begin
            m_sum <= 0;
            if (num_terms == '0) begin
                m_done <= 1'b1;
            end else begin
                m_run  <= 1'b1;
                m_left <= (int'(num_terms) > MAXT) ? MAXT : int'(num_terms);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("acc_out40",  64'(if40.acc_out),    64'(m_sum[39:0]));
            chk("overflow40", 64'(if40.overflow),   64'(|m_sum[63:40]));
            chk("acc_out32",  64'(if32.acc_out),    64'(m_sum[31:0]));
            chk("overflow32", 64'(if32.overflow),   64'(|m_sum[63:32]));
            chk("acc_valid40", 64'(if40.acc_valid), 64'(m_done));
            chk("acc_valid32", 64'(if32.acc_valid), 64'(m_done));
            chk("prod_ready40", 64'(if40.prod_ready), 64'(m_run));
            chk("prod_ready32", 64'(if32.prod_ready), 64'(m_run));
            chk("busy40", 64'(if40.busy), 64'(m_run | m_done));
            chk("busy32", 64'(if32.busy), 64'(m_run | m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_terms = CNT_W'(n);
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic [PROD_W-1:0] p);
        int k = 0;
        prod_valid = 1'b1;
        prod_in    = p;
        while (!if40.prod_ready && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: prod_ready stayed 0 for %0d cycles, required 1", k);
        end
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic do_ack();
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        reset = 1'b0; start = 1'b0; num_terms = '0;
        prod_valid = 1'b0; prod_in = '0; acc_ack = 1'b0;
        tick(); tick();
        chk("rst_acc_out",  64'(if40.acc_out),    64'd0);
        chk("rst_valid",    64'(if40.acc_valid),  64'd0);
        chk("rst_busy",     64'(if40.busy),       64'd0);
        chk("rst_ready",    64'(if40.prod_ready), 64'd0);
        reset = 1'b1;
        tick();

        // 1: three back-to-back products
        do_start(3);
        send(32'd10); send(32'd20); send(32'd30);
        chk("t1_valid", 64'(if40.acc_valid), 64'd1);
        chk("t1_sum",   64'(if40.acc_out),   64'd60);
        chk("t1_ovf",   64'(if40.overflow),  64'd0);
        do_ack();

        // 2: four products with two-cycle gaps
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            send(32'd5);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    chk("t2_ready_gap", 64'(if40.prod_ready), 64'd1);
                    tick();
                end
            end
        end
        chk("t2_sum",   64'(if40.acc_out),   64'd20);
        chk("t2_valid", 64'(if40.acc_valid), 64'd1);
        do_ack();

        // 3: wrap on the 32-bit instance, then a clean run
        do_start(2);
        send(32'hFFFF_FFFF); send(32'd2);
        chk("t3_sum32", 64'(if32.acc_out),  64'd1);
        chk("t3_ovf32", 64'(if32.overflow), 64'd1);
        chk("t3_sum40", 64'(if40.acc_out),  64'h1_0000_0001);
        chk("t3_ovf40", 64'(if40.overflow), 64'd0);
        do_ack();
        do_start(2);
        chk("t3_ovf_clr", 64'(if32.overflow), 64'd0);
        send(32'd3); send(32'd4);
        chk("t3b_sum32", 64'(if32.acc_out),  64'd7);
        chk("t3b_ovf32", 64'(if32.overflow), 64'd0);
        do_ack();

        // 4: empty run, then a clamped request of 31 terms
        do_start(0);
        chk("t4_zero_valid", 64'(if40.acc_valid), 64'd1);
        chk("t4_zero_sum",   64'(if40.acc_out),   64'd0);
        do_ack();
        do_start(31);
        for (int i = 0; i < 16; i++) send(32'd1);
        chk("t4_clamp_valid", 64'(if40.acc_valid),  64'd1);
        chk("t4_clamp_ready", 64'(if40.prod_ready), 64'd0);
        prod_valid = 1'b1; prod_in = 32'd100;
        tick(); tick();
        prod_valid = 1'b0;
        chk("t4_clamp_sum", 64'(if40.acc_out), 64'd16);

        // 5: hold without ack, start ignored, then ack with start
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); num_terms = 5'd2;
            tick();
            chk("t5_hold_sum",   64'(if40.acc_out),   64'd16);
            chk("t5_hold_valid", 64'(if40.acc_valid), 64'd1);
        end
        start = 1'b1; num_terms = 5'd3; acc_ack = 1'b1;
        tick();
        start = 1'b0; acc_ack = 1'b0;
        chk("t5_ack_busy",  64'(if40.busy),      64'd0);
        chk("t5_ack_valid", 64'(if40.acc_valid), 64'd0);
        tick();
        chk("t5_idle_busy", 64'(if40.busy), 64'd0);

        // 6: reset mid-run, then a fresh run
        do_start(4);
        send(32'd7); send(32'd9);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_rst_sum",   64'(if40.acc_out),    64'd0);
        chk("t6_rst_busy",  64'(if40.busy),       64'd0);
        chk("t6_rst_ready", 64'(if40.prod_ready), 64'd0);
        do_start(2);
        send(32'd3); send(32'd3);
        chk("t6_sum",   64'(if40.acc_out),   64'd6);
        chk("t6_valid", 64'(if40.acc_valid), 64'd1);
        do_ack();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
